xversat_cmd_seq: RTL and testbench

XVERSAT_CMD_SEQ -- requirements
Module: xversat_cmd_seq

---
 rtl/xversat_cmd_seq.sv | 182 ++++++++++++++++++
 tb/tb_xversat_cmd_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xversat_cmd_seq.sv
// xversat_cmd_seq: buffers host config writes, replays them to versat,
// starts a run, then polls the status word until done or timeout.
module xversat_cmd_seq #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RUN_ADDR  = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 32'h0000_0000,
    parameter int                SETTLE    = 4,
    parameter int                TIMEOUT   = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    input  logic                     cmd_last,
    output logic                     valid,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        wdata,
    output logic                     wstrb,
    input  logic                     ready,
    input  logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + ADDR_W + DATA_W;
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_SETTLE,
        S_POLL,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [AW:0]     level_q;
    logic [EW-1:0]   mem [DEPTH];
    logic [SW-1:0]   settle_q;
    logic [TW-1:0]   tmo_q;
    logic            err_q;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    logic            head_last;
    logic            unused_rdata;

    assign empty     = (level_q == '0);
    assign full      = (level_q == (AW+1)'(DEPTH));
    assign push      = cmd_valid & ~full;
    assign head      = mem[rptr_q];
    assign head_last = head[EW-1];
    assign pop       = (state_q == S_ISSUE) & ~empty & ready;

    assign cmd_ready    = ~full;
    assign level        = level_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign unused_rdata = ^rdata[DATA_W-1:1];

    // Storage array; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= {cmd_last, cmd_addr, cmd_wdata};
    end

    // FIFO pointers and occupancy; a push at full is refused even with a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sequencer: replay config, run write, settle delay, status polling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (pop && head_last) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (ready) begin
                        settle_q <= SW'(SETTLE);
                        state_q  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SW'(1)) begin
                        settle_q <= '0;
                        tmo_q    <= '0;
                        state_q  <= S_POLL;
                    end else begin
                        settle_q <= settle_q - SW'(1);
                    end
                end
                S_POLL: begin
                    if (ready) begin
                        if (rdata[0]) begin
                            tmo_q   <= '0;
                            state_q <= S_DONE;
                        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                            tmo_q   <= '0;
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Versat request mux; address/data/strobe forced to zero when idle.
    always_comb begin
        valid = 1'b0;
        addr  = '0;
        wdata = '0;
        wstrb = 1'b0;
        unique case (state_q)
            S_ISSUE: begin
                if (!empty) begin
                    valid = 1'b1;
                    wstrb = 1'b1;
                    addr  = head[ADDR_W+DATA_W-1:DATA_W];
                    wdata = head[DATA_W-1:0];
                end
            end
            S_RUN: begin
                valid = 1'b1;
                wstrb = 1'b1;
                addr  = RUN_ADDR;
            end
            S_POLL: begin
                valid = 1'b1;
                addr  = STAT_ADDR;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_xversat_cmd_seq.sv
// tb_xversat_cmd_seq: directed bench for the versat command sequencer.
// Drives inputs and samples outputs on the falling clock edge.
module tb_xversat_cmd_seq;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_last;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  level;

    int checks = 0;
    int errors = 0;

    xversat_cmd_seq #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_last  (cmd_last),
        .valid     (valid),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .ready     (ready),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic v,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic s);
        chk({tag, ".valid"}, {63'd0, valid}, {63'd0, v});
        chk({tag, ".addr"}, {32'd0, addr}, {32'd0, a});
        chk({tag, ".wdata"}, {32'd0, wdata}, {32'd0, d});
        chk({tag, ".wstrb"}, {63'd0, wstrb}, {63'd0, s});
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_last  = l;
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_last  = 1'b0;
    endtask

    logic [31:0] log4 [$];
    logic [31:0] exp4 [8];
    int polls;
    int dseen;
    bit started;

    initial begin
        rst   = 1'b0;
        ready = 1'b0;
        rdata = '0;
        idle_cmd();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst.level", 64'(level), 64'd0);
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        chk_req("rst", 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;

        // Single set: three writes, run, settle, polls, done
        ready = 1'b1;
        push(32'h10, 32'hA, 1'b0);
        @(negedge clk);
        chk("t1.idle_valid", 64'(valid), 64'd0);
        chk("t1.level1", 64'(level), 64'd1);
        push(32'h14, 32'hB, 1'b0);
        @(negedge clk);
        chk_req("t1.w0", 1'b1, 32'h10, 32'hA, 1'b1);
        chk("t1.level2", 64'(level), 64'd2);
        push(32'h18, 32'hC, 1'b1);
        @(negedge clk);
        chk_req("t1.w1", 1'b1, 32'h14, 32'hB, 1'b1);
        chk("t1.level_pp", 64'(level), 64'd2);
        idle_cmd();
        @(negedge clk);
        chk_req("t1.w2", 1'b1, 32'h18, 32'hC, 1'b1);
        chk("t1.level3", 64'(level), 64'd1);
        @(negedge clk);
        chk_req("t1.run", 1'b1, 32'h8000_0000, 32'h0, 1'b1);
        chk("t1.level0", 64'(level), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_req("t1.settle", 1'b0, 32'h0, 32'h0, 1'b0);
            chk("t1.settle_busy", 64'(busy), 64'd1);
        end
        @(negedge clk);
        chk_req("t1.poll0", 1'b1, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk_req("t1.poll1", 1'b1, 32'h0, 32'h0, 1'b0);
        chk("t1.no_done_yet", 64'(done), 64'd0);
        rdata = 32'h1;
        @(negedge clk);
        chk("t1.done", 64'(done), 64'd1);
        chk("t1.done_valid", 64'(valid), 64'd0);
        rdata = 32'h0;
        @(negedge clk);
        chk("t1.done_pulse", 64'(done), 64'd0);
        chk("t1.idle_busy", 64'(busy), 64'd0);

        // Fill FIFO with ready low, refuse at full, drain while pushing
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(4 * i), 32'(i), 1'b0);
            @(negedge clk);
        end
        chk("t2.level_full", 64'(level), 64'd8);
        chk("t2.cmd_ready0", 64'(cmd_ready), 64'd0);
        chk_req("t2.head", 1'b1, 32'h100, 32'h0, 1'b1);
        push(32'h200, 32'h99, 1'b1);
        @(negedge clk);
        chk("t2.refused", 64'(level), 64'd8);
        ready = 1'b1;
        @(negedge clk);
        chk("t2.pop_at_full", 64'(level), 64'd7);
        chk("t2.cmd_ready1", 64'(cmd_ready), 64'd1);
        chk("t2.head1", 64'(addr), 64'h104);
        @(negedge clk);
        chk("t2.push_pop", 64'(level), 64'd7);
        chk("t2.head2", 64'(addr), 64'h108);
        idle_cmd();
        repeat (6) @(negedge clk);
        chk_req("t2.ninth", 1'b1, 32'h200, 32'h99, 1'b1);
        chk("t2.level_last", 64'(level), 64'd1);
        @(negedge clk);
        chk_req("t2.run", 1'b1, 32'h8000_0000, 32'h0, 1'b1);
        rdata = 32'h1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("t2.done", 64'(done), 64'd1);
        rdata = 32'h0;
        @(negedge clk);
        chk("t2.idle", 64'(busy), 64'd0);

        // Poll timeout: exactly 16 reads, sticky err, no done
        push(32'h40, 32'h7, 1'b1);
        @(negedge clk);
        idle_cmd();
        polls   = 0;
        dseen   = 0;
        started = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (valid && !wstrb && ready) polls++;
            if (done) dseen++;
            if (busy) started = 1'b1;
            else if (started) break;
            @(negedge clk);
        end
        chk("t3.polls", 64'(polls), 64'd16);
        chk("t3.no_done", 64'(dseen), 64'd0);
        chk("t3.err", 64'(err), 64'd1);
        chk("t3.busy", 64'(busy), 64'd0);
        chk("t3.valid", 64'(valid), 64'd0);

        // Two sets back to back; second set waits for first done
        rdata = 32'h1;
        exp4 = '{32'h50, 32'h54, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h60, 32'h64, 32'h8000_0000, 32'hFFFF_FFFF};
        log4.delete();
        dseen = 0;
        for (int i = 0; i < 80; i++) begin
            unique case (i)
                0: push(32'h50, 32'h1, 1'b0);
                1: push(32'h54, 32'h2, 1'b1);
                2: push(32'h60, 32'h3, 1'b0);
                3: push(32'h64, 32'h4, 1'b1);
                default: idle_cmd();
            endcase
            @(negedge clk);
            if (valid && ready && wstrb) log4.push_back(addr);
            if (done) begin
                log4.push_back(32'hFFFF_FFFF);
                dseen++;
            end
            if (dseen == 2) break;
        end
        idle_cmd();
        chk("t4.events", 64'(log4.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log4.size())
                chk($sformatf("t4.ev%0d", i), 64'(log4[i]), 64'(exp4[i]));
        end
        chk("t4.err_sticky", 64'(err), 64'd1);
        rdata = 32'h0;

        // Reset during POLL with entries queued
        push(32'h70, 32'h1, 1'b1);
        @(negedge clk);
        push(32'h74, 32'h2, 1'b0);
        @(negedge clk);
        push(32'h78, 32'h3, 1'b0);
        @(negedge clk);
        push(32'h7C, 32'h4, 1'b0);
        @(negedge clk);
        idle_cmd();
        dseen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid && !wstrb) break;
            if (done) dseen++;
            @(negedge clk);
        end
        chk_req("t5.in_poll", 1'b1, 32'h0, 32'h0, 1'b0);
        chk("t5.level3", 64'(level), 64'd3);
        rst = 1'b0;
        #1;
        chk_req("t5.rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t5.level0", 64'(level), 64'd0);
        chk("t5.busy", 64'(busy), 64'd0);
        chk("t5.err", 64'(err), 64'd0);
        chk("t5.cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        if (done) dseen++;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        chk("t5.no_done", 64'(dseen), 64'd0);
        chk("t5.stays_idle", 64'(busy), 64'd0);
        chk("t5.fifo_gone", 64'(level), 64'd0);
        chk("t5.valid_after", 64'(valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
